dvi_tx_sequencer: RTL and testbench

//  Power-up/hot-plug sequencer for the DVI transmit path, in the pixel clock domain.

---
 rtl/dvi_tx_sequencer_pkg.sv | 17 +
 rtl/dvi_tx_sequencer_sync_debounce.sv | 41 ++++
 rtl/dvi_tx_sequencer.sv | 158 +++++++++++++++
 tb/tb_dvi_tx_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_tx_sequencer_pkg.sv
// Shared state codes and counter sizing for the DVI transmit sequencer.
package dvi_tx_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_SER_RST   = 3'd1,
      ST_WAIT_HPD  = 3'd2,
      ST_START     = 3'd3,
      ST_BLANK     = 3'd4,
      ST_ACTIVE    = 3'd5
   } state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dvi_tx_sequencer_sync_debounce.sv
// Two-flop synchronizer for hot-plug detect, followed by a stability debounce.
module sync_debounce
   import dvi_tx_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 742500
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   // dout only follows sync after it has disagreed for a full run of cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         if (sync == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            dout <= sync;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/dvi_tx_sequencer.sv
// Power-up / hot-plug sequencer for the DVI transmit path (pixel clock domain).
// Define DVI_SEQ_HPD_EN to build the hot-plug synchronizer and debounce.
module dvi_tx_sequencer
   import dvi_tx_sequencer_pkg::*;
#(
   parameter int SER_RST_CYCLES  = 16,
   parameter int DEBOUNCE_CYCLES = 742500,
   parameter int BLANK_FRAMES    = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clk_lock,
   input  logic       i_hpd,
   input  logic       i_frame,
   output logic       o_timing_rst,
   output logic       o_dvi_rst,
   output logic       o_blank,
   output logic       o_active,
   output logic [2:0] o_state
);

   localparam int SW = cnt_w(SER_RST_CYCLES);
   localparam int FW = cnt_w(BLANK_FRAMES);
   localparam logic [SW-1:0] SER_LAST = SW'(SER_RST_CYCLES - 1);
   localparam logic [FW-1:0] FRM_LAST =
      FW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

   state_t        state, state_n;
   logic [SW-1:0] ser_cnt, ser_n;
   logic [FW-1:0] frm_cnt, frm_n;
   logic          lock_m, lock_s;
   logic          hpd_db;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= i_clk_lock;
         lock_s <= lock_m;
      end
   end

`ifdef DVI_SEQ_HPD_EN
   sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_hpd (
      .clk (i_clk),
      .rst (i_rst),
      .din (i_hpd),
      .dout(hpd_db)
   );
`else
   logic unused_hpd;
   assign unused_hpd = i_hpd;
   assign hpd_db     = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_WAIT_LOCK;
         ser_cnt <= '0;
         frm_cnt <= '0;
      end else begin
         state   <= state_n;
         ser_cnt <= ser_n;
         frm_cnt <= frm_n;
      end
   end

   // Lock loss outranks every other event, including HPD loss and frames
   always_comb begin
      state_n = state;
      ser_n   = ser_cnt;
      frm_n   = frm_cnt;
      if (state != ST_WAIT_LOCK && !lock_s) begin
         state_n = ST_WAIT_LOCK;
         ser_n   = '0;
         frm_n   = '0;
      end else begin
         case (state)
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_n = ST_SER_RST;
                  ser_n   = '0;
               end
            end
            ST_SER_RST: begin
               if (ser_cnt == SER_LAST) begin
                  state_n = ST_WAIT_HPD;
                  ser_n   = '0;
               end else begin
                  ser_n = ser_cnt + SW'(1);
               end
            end
            ST_WAIT_HPD: begin
               if (hpd_db) state_n = ST_START;
            end
            ST_START: begin
               if (!hpd_db) begin
                  state_n = ST_WAIT_HPD;
                  frm_n   = '0;
               end else if (i_frame) begin
                  state_n = (BLANK_FRAMES == 0) ? ST_ACTIVE : ST_BLANK;
                  frm_n   = '0;
               end
            end
            ST_BLANK: begin
               if (!hpd_db) begin
                  state_n = ST_WAIT_HPD;
                  frm_n   = '0;
               end else if (i_frame) begin
                  if (frm_cnt == FRM_LAST) state_n = ST_ACTIVE;
                  else frm_n = frm_cnt + FW'(1);
               end
            end
            ST_ACTIVE: begin
               if (!hpd_db) begin
                  state_n = ST_WAIT_HPD;
                  frm_n   = '0;
               end
            end
            default: begin
               state_n = ST_WAIT_LOCK;
               ser_n   = '0;
               frm_n   = '0;
            end
         endcase
      end
   end

   always_comb begin
      o_timing_rst = 1'b1;
      o_dvi_rst    = 1'b1;
      o_blank      = 1'b1;
      o_active     = 1'b0;
      unique case (state)
         ST_WAIT_LOCK,
         ST_SER_RST: ;
         ST_WAIT_HPD: o_dvi_rst = 1'b0;
         ST_START,
         ST_BLANK: begin
            o_timing_rst = 1'b0;
            o_dvi_rst    = 1'b0;
         end
         ST_ACTIVE: begin
            o_timing_rst = 1'b0;
            o_dvi_rst    = 1'b0;
            o_blank      = 1'b0;
            o_active     = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_state = state;

endmodule

// File: tb/tb_dvi_tx_sequencer.sv
// Self-checking bench for dvi_tx_sequencer: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_dvi_tx_sequencer;

   localparam int SER = 4;
   localparam int DEB = 8;
   localparam int BF  = 2;
`ifdef DVI_SEQ_HPD_EN
   localparam bit HPD_EN = 1'b1;
`else
   localparam bit HPD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lock = 1'b0;
   logic       hpd = 1'b0;
   logic       frame = 1'b0;
   logic       timing_rst, dvi_rst, blank, active;
   logic [2:0] state;

   int n_chk = 0;
   int n_fail = 0;

   // Model: phase 0..5 in bring-up order, plus elapsed-time counters
   int m_ph, m_ser, m_fr, m_run;
   bit m_l1, m_l2, m_h1, m_h2, m_hdb;

   always #5 clk = ~clk;

   dvi_tx_sequencer #(
      .SER_RST_CYCLES (SER),
      .DEBOUNCE_CYCLES(DEB),
      .BLANK_FRAMES   (BF)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_clk_lock  (lock),
      .i_hpd       (hpd),
      .i_frame     (frame),
      .o_timing_rst(timing_rst),
      .o_dvi_rst   (dvi_rst),
      .o_blank     (blank),
      .o_active    (active),
      .o_state     (state)
   );

   always @(posedge clk) begin
      int nph;
      bit plugged;
      if (rst) begin
         m_ph = 0; m_ser = 0; m_fr = 0; m_run = 0;
         m_l1 = 0; m_l2 = 0; m_h1 = 0; m_h2 = 0; m_hdb = 0;
      end else begin
         plugged = HPD_EN ? m_hdb : 1'b1;
         nph = m_ph;
         if (m_ph != 0 && !m_l2) nph = 0;
         else if (m_ph == 0) begin
            if (m_l2) begin nph = 1; m_ser = 0; end
         end else if (m_ph == 1) begin
            m_ser++;
            if (m_ser == SER) nph = 2;
         end else if (m_ph == 2) begin
            if (plugged) nph = 3;
         end else if (!plugged) nph = 2;
         else if (frame && m_ph < 5) begin
            m_fr++;
            nph = (m_fr >= 1 + BF) ? 5 : 4;
         end
         if (nph < 4) m_fr = 0;
         if (m_h2 != m_hdb) begin
            m_run++;
            if (m_run == DEB) begin m_hdb = m_h2; m_run = 0; end
         end else m_run = 0;
         m_l2 = m_l1; m_l1 = lock;
         m_h2 = m_h1; m_h1 = hpd;
         m_ph = nph;
      end
   end

   function automatic logic [6:0] exp_vec(input int ph);
      return {ph < 3, ph < 2, ph < 5, ph == 5, 3'(ph)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim,
                             output int got);
      got = -1;
      for (int i = 1; i <= lim; i++) begin
         tick();
         if (state === s) begin got = i; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_chk++;
      if ({timing_rst, dvi_rst, blank, active, state} !== 7'b1110_000) begin
         n_fail++;
         $display("FAIL reset: got %b want %b",
                  {timing_rst, dvi_rst, blank, active, state}, 7'b1110_000);
      end
      rst = 1'b0;
   endtask

   task automatic test_bringup();
      int got;
      hpd = HPD_EN;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_chk++;
         if (state !== 3'd0 || dvi_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL prelock: state %0d dvi_rst %b want 0/1",
                     state, dvi_rst);
         end
      end
      lock = 1'b1;
      got = -1;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (dvi_rst === 1'b0) begin got = i; break; end
      end
      n_chk++;
      if (got != 2 + 1 + SER) begin
         n_fail++;
         $display("FAIL lock_latency: got %0d want %0d", got, 3 + SER);
      end
      tick();
      n_chk++;
      if (timing_rst !== 1'b0 || state !== 3'd3) begin
         n_fail++;
         $display("FAIL timing_release: trst %b state %0d want 0/3",
                  timing_rst, state);
      end
   endtask

   task automatic test_frames();
      for (int k = 1; k <= 1 + BF; k++) begin
         frame = 1'b1;
         tick();
         frame = 1'b0;
         n_chk++;
         if (state !== ((k == 1 + BF) ? 3'd5 : 3'd4)) begin
            n_fail++;
            $display("FAIL frame_%0d: state %0d want %0d", k, state,
                     (k == 1 + BF) ? 5 : 4);
         end
         if (k < 1 + BF) begin
            for (int i = 0; i < 19; i++) begin
               tick();
               n_chk++;
               if (blank !== 1'b1 || active !== 1'b0) begin
                  n_fail++;
                  $display("FAIL blank_hold: blank %b active %b want 1/0",
                           blank, active);
               end
            end
         end
      end
      n_chk++;
      if (blank !== 1'b0 || active !== 1'b1) begin
         n_fail++;
         $display("FAIL active: blank %b active %b want 0/1", blank, active);
      end
   endtask

   task automatic test_unplug();
      int got;
      hpd = 1'b0;
      wait_state(3'd2, 40, got);
      n_chk++;
      if (got != 2 + DEB + 1) begin
         n_fail++;
         $display("FAIL unplug_latency: got %0d want %0d", got, DEB + 3);
      end
      n_chk++;
      if ({timing_rst, dvi_rst, blank, active} !== 4'b1010) begin
         n_fail++;
         $display("FAIL unplug_out: got %b want 1010",
                  {timing_rst, dvi_rst, blank, active});
      end
   endtask

   task automatic test_hpd_glitch();
      int got;
      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < 10; i++) begin
            hpd = (i < 5);
            tick();
            n_chk++;
            if (state !== 3'd2) begin
               n_fail++;
               $display("FAIL glitch: state %0d want 2", state);
            end
         end
      end
      hpd = 1'b1;
      wait_state(3'd3, 40, got);
      n_chk++;
      if (got != 2 + DEB + 1) begin
         n_fail++;
         $display("FAIL replug_latency: got %0d want %0d", got, DEB + 3);
      end
   endtask

   task automatic test_lock_loss();
      int got;
      lock = 1'b0;
      if (HPD_EN) hpd = 1'b0;
      wait_state(3'd0, 20, got);
      n_chk++;
      if (got != 3) begin
         n_fail++;
         $display("FAIL lockloss_latency: got %0d want 3", got);
      end
      n_chk++;
      if ({timing_rst, dvi_rst, blank, active} !== 4'b1110) begin
         n_fail++;
         $display("FAIL lockloss_out: got %b want 1110",
                  {timing_rst, dvi_rst, blank, active});
      end
   endtask

   task automatic test_rst_mid_blank();
      int got;
      lock = 1'b1;
      hpd = HPD_EN;
      wait_state(3'd3, 100, got);
      n_chk++;
      if (got < 0) begin
         n_fail++;
         $display("FAIL relock: got %0d want reach START", got);
      end
      frame = 1'b1;
      tick();
      frame = 1'b0;
      n_chk++;
      if (state !== 3'd4) begin
         n_fail++;
         $display("FAIL enter_blank: state %0d want 4", state);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if (state !== 3'd0 || dvi_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_blank: state %0d dvi_rst %b want 0/1",
                  state, dvi_rst);
      end
   endtask

   task automatic test_random();
      logic [6:0] want;
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 699) == 0);
         if ($urandom_range(0, 249) == 0) lock = ~lock;
         if ($urandom_range(0, 39) == 0) hpd = ~hpd;
         frame = ($urandom_range(0, 11) == 0);
         if (c < 50) begin lock = 1'b1; hpd = 1'b1; end
         tick();
         want = exp_vec(m_ph);
         n_chk++;
         if ({timing_rst, dvi_rst, blank, active, state} !== want) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %b want %b", c,
                     {timing_rst, dvi_rst, blank, active, state}, want);
         end
      end
      rst = 1'b0;
      frame = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_frames();
      if (HPD_EN) begin
         test_unplug();
         test_hpd_glitch();
         test_frames();
      end
      test_lock_loss();
      test_rst_mid_blank();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
